inv_mix_columns: RTL and testbench
==================================

INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide port: in_data  input  128  AES state; byte i at bits [127-8i -: 8]; column c = bytes 4c..4c+3.
REQ-004 SHALL provide port: in_valid  input  1  in_data valid.
REQ-005 SHALL provide port: in_ready  output  1  block can accept a state.
REQ-006 SHALL provide port: out_data  output  128  InvMixColumns result, same byte order as in_data.
REQ-007 SHALL provide port: out_valid  output  1  out_data valid.
REQ-008 SHALL provide port: out_ready  input  1  consumer accepts out_data.
REQ-009 SHALL provide port: busy  output  1  high in BUSY state.

Function
REQ-010 SHALL compute per column (a0..a3 -> b0..b3) over GF(2^8), poly 0x11B: b0=0e·a0^0b·a1^0d·a2^09·a3; b1=09·a0^0e·a1^0b·a2^0d·a3; b2=0d·a0^09·a1^0e·a2^0b·a3; b3=0b·a0^0d·a1^09·a2^0e·a3.
REQ-011 SHALL build constant multiplies from xtime only: xtime(x) = (x<<1)[7:0] ^ (x[7] ? 0x1B : 0x00), where x[7] is the MSB of the byte being doubled.
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 SHALL, on in_valid&&in_ready at edge E0, latch in_data into a 128-bit working register, clear 2-bit column counter, and enter BUSY.
REQ-015 SHALL process exactly one column per cycle in BUSY: at edge E(k+1), column k result overwrites column k of the working register (k=0..3).
REQ-016 SHALL, at the edge writing column 3 (E4), enter DONE; out_valid first high in the cycle after E4 (accept-to-out_valid latency = 4 cycles).
REQ-017 SHALL drive out_data from the working register; out_data stable while out_valid=1 and out_ready=0.
REQ-018 SHALL, on out_valid&&out_ready, return to IDLE at that edge; in_ready rises in the following cycle (no accept in the same cycle as output handshake).
REQ-019 SHALL ignore in_valid while not in IDLE; in_data changes outside the accepting cycle have no effect.
REQ-020 SHALL hold DONE indefinitely while out_ready=0 (backpressure, no data loss).
REQ-021 SHALL wrap the column counter 3->0 only on leaving BUSY; counter value in IDLE/DONE is don't-care internally, never observable.
REQ-022 SHALL sustain throughput of one state per 6 cycles with out_ready held high.

Reset
REQ-023 SHALL, on rst low, immediately (asynchronously) enter IDLE: in_ready=1, out_valid=0, busy=0, out_data=128'h0, counter=0.
REQ-024 SHALL abort any in-flight state on reset mid-BUSY or mid-DONE; no out_valid pulse follows reset deassertion.
REQ-025 SHALL release reset synchronously-safe: first accept possible at first rising edge with rst high.

Structure
REQ-026 SHALL place xtime and gf_mul constants (0x09,0x0B,0x0D,0x0E), reduction constant 0x1B, and FSM state typedef in shared package aes_pkg.
REQ-027 SHALL instantiate one combinational sub-module inv_mix_column (32-bit column in/out), shared across the four column iterations via a mux on the counter.

Verification
REQ-028 SHALL cover: column db135345 mix-inverse vector: in_data=8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> out_data=db135345_f20a225c_01010101_d4d4d4d5 exactly 4 cycles after accept.
REQ-029 SHALL cover: in_data=c6c6c6c6 repeated ×4 -> identical out_data; in_data all-zero -> all-zero.
REQ-030 SHALL cover: out_ready low 10 cycles in DONE -> out_valid and out_data held, in_ready=0 throughout, in_valid pulses ignored.
REQ-031 SHALL cover: rst asserted at E2 of a BUSY run -> outputs at reset values same cycle; next accepted vector 2d26314c... produces correct result unaffected by aborted data.
REQ-032 SHALL cover: back-to-back random states with out_ready=1 -> every result equals software model, and mixColumns(inv_mix_columns(x))=x for 1000 random x.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) xtime-based constant multipliers and the
// InvMixColumns controller state encoding.
package aes_pkg;

    localparam logic [7:0] GF_REDUCE = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? GF_REDUCE : 8'h00);
    endfunction

    // Each multiplier is a sum of x, 2x, 4x and 8x picked by the constant's bits.
    function automatic logic [7:0] gf_mul09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 32-bit column (a0 in the top byte).
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] result
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    assign result[31:24] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
    assign result[23:16] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
    assign result[15:8]  = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
    assign result[7:0]   = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);

endmodule

// File: rtl/inv_mix_columns.sv
// Iterative InvMixColumns: one shared column unit rewrites the working state
// one column per cycle, then holds the result until the consumer takes it.
module inv_mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    state_t       state, state_next;
    logic [1:0]   col_idx;
    logic [127:0] work;
    logic [31:0]  col_in, col_out;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign out_data  = work;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        col_in = work[127:96];
        case (col_idx)
            2'd1:    col_in = work[95:64];
            2'd2:    col_in = work[63:32];
            2'd3:    col_in = work[31:0];
            default: col_in = work[127:96];
        endcase
    end

    inv_mix_column u_col (
        .col    (col_in),
        .result (col_out)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)          state_next = BUSY;
            BUSY:    if (col_idx == 2'd3)   state_next = DONE;
            DONE:    if (out_ready)         state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: the working register is reset because its value is visible on out_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work    <= '0;
            col_idx <= 2'd0;
        end else if (state == IDLE && in_valid) begin
            work    <= in_data;
            col_idx <= 2'd0;
        end else if (state == BUSY) begin
            // Counter wraps 3->0 on the same edge that leaves BUSY.
            col_idx <= col_idx + 2'd1;
            case (col_idx)
                2'd0:    work[127:96] <= col_out;
                2'd1:    work[95:64]  <= col_out;
                2'd2:    work[63:32]  <= col_out;
                default: work[31:0]   <= col_out;
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed and random checks of inv_mix_columns: reset, known vectors,
// backpressure, reset abort and back-to-back throughput with round-trip.
module tb_inv_mix_columns;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inv_mix_columns dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    // Generic shift-and-add GF(2^8) multiply, independent of the RTL structure.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Circulant column transform: b_r = sum_j k[(j-r)&3] * a_j.
    function automatic logic [127:0] col_mix(input logic [127:0] s, input logic [31:0] coef);
        logic [127:0] r;
        logic [7:0]   k [4];
        logic [7:0]   acc;
        k[0] = coef[31:24]; k[1] = coef[23:16]; k[2] = coef[15:8]; k[3] = coef[7:0];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(k[(j - row) & 3], s[127 - 8 * (4 * c + j) -: 8]);
                r[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_model(input logic [127:0] s);
        return col_mix(s, 32'h0E0B0D09);
    endfunction

    function automatic logic [127:0] fwd_model(input logic [127:0] s);
        return col_mix(s, 32'h02030101);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents d for one edge, then scrambles in_data to prove it is not re-sampled.
    task automatic send(input logic [127:0] d);
        in_data  = d;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        in_data  = ~d;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = {4{32'hdeadbeef}}; out_ready = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags got=%b want=100", {in_ready, out_valid, busy});
        end
        checks++;
        if (out_data !== 128'h0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", out_data);
        end
        cycle();
        cycle();
        checks++;
        if ({in_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_hold got=%b want=10", {in_ready, busy});
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
    endtask

    task automatic test_known_vector();
        int n;
        out_ready = 1'b1;
        send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b010) begin
            failures++;
            $display("FAIL accept_flags got=%b want=010", {in_ready, busy, out_valid});
        end
        wait_out(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL latency got=%0d want=4", n);
        end
        checks++;
        if (out_data !== 128'hdb135345_f20a225c_01010101_d4d4d4d5) begin
            failures++;
            $display("FAIL known_vector got=%h want=db135345f20a225c01010101d4d4d4d5", out_data);
        end
        cycle();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL return_idle got=%b want=10", {in_ready, out_valid});
        end
    endtask

    task automatic test_uniform();
        int n;
        logic [127:0] vecs [2];
        vecs[0] = {4{32'hc6c6c6c6}};
        vecs[1] = 128'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(vecs[i]);
            wait_out(n);
            checks++;
            if (out_data !== vecs[i] || n != 4) begin
                failures++;
                $display("FAIL uniform_%0d got=%h lat=%0d want=%h lat=4", i, out_data, n, vecs[i]);
            end
            cycle();
        end
    endtask

    task automatic test_backpressure();
        int n;
        int stray;
        out_ready = 1'b0;
        send(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6);
        wait_out(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL bp_latency got=%0d want=4", n);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b100 ||
                out_data !== 128'hdb135345_f20a225c_01010101_d4d4d4d5) begin
                failures++;
                $display("FAIL bp_hold_%0d flags=%b data=%h want flags=100 data=db135345f20a225c01010101d4d4d4d5",
                         i, {out_valid, in_ready, busy}, out_data);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release got=%b want=10", {in_ready, out_valid});
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL bp_ignored_pulses got=%0d active cycles want=0", stray);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int stray;
        logic [127:0] vec_b;
        logic [127:0] exp_b;
        out_ready = 1'b1;
        send({4{32'h12345678}});
        cycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_data !== 128'h0) begin
            failures++;
            $display("FAIL abort_reset flags=%b data=%h want flags=100 data=0",
                     {in_ready, out_valid, busy}, out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (out_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_no_output got=%0d valid cycles want=0", stray);
        end
        vec_b = 128'h2d26314c_4d7ebdf8_c6c6c6c6_01010101;
        exp_b = inv_model(vec_b);
        send(vec_b);
        wait_out(n);
        checks++;
        if (out_data[95:64] !== 32'h2d26314c || out_data[63:0] !== 64'hc6c6c6c6_01010101) begin
            failures++;
            $display("FAIL abort_next_hand got=%h want=2d26314cc6c6c6c601010101 in low 96 bits", out_data[95:0]);
        end
        checks++;
        if (out_data !== exp_b || n != 4) begin
            failures++;
            $display("FAIL abort_next_model got=%h lat=%0d want=%h lat=4", out_data, n, exp_b);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int n;
        time t_prev;
        logic [127:0] x;
        logic [127:0] exp_y;
        out_ready = 1'b1;
        t_prev = 0;
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            exp_y = inv_model(x);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready_%0d got=%b want=1", i, in_ready);
            end
            in_data  = x;
            in_valid = 1'b1;
            @(posedge clk);
            if (i > 0) begin
                checks++;
                if ($time - t_prev != 60) begin
                    failures++;
                    $display("FAIL b2b_interval_%0d got=%0t want=60", i, $time - t_prev);
                end
            end
            t_prev = $time;
            #1;
            in_valid = 1'b0;
            in_data  = ~x;
            wait_out(n);
            checks++;
            if (n != 4 || out_data !== exp_y) begin
                failures++;
                $display("FAIL b2b_result_%0d got=%h lat=%0d want=%h lat=4", i, out_data, n, exp_y);
            end
            checks++;
            if (fwd_model(out_data) !== x) begin
                failures++;
                $display("FAIL b2b_roundtrip_%0d got=%h want=%h", i, fwd_model(out_data), x);
            end
            cycle();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_known_vector();
        test_uniform();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
